// File: rtl/ab_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ab_cond_pkg
//  Description : Shared constants for the a/b input conditioner: the 2-bit
//                debounce state encoding, the default debounce depth and a
//                helper that maps a state onto its stable output level.
//  Revision    : 1.0  - initial release
// ============================================================================
package ab_cond_pkg;

    // Debounce FSM state encoding. Bit 1 doubles as the stable level:
    // LOW/CHK_HIGH present 0, HIGH/CHK_LOW present 1.
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_LOW      = 2'b00;
    localparam logic [1:0] ST_CHK_HIGH = 2'b01;
    localparam logic [1:0] ST_HIGH     = 2'b10;
    localparam logic [1:0] ST_CHK_LOW  = 2'b11;

    // Consecutive synchronised samples at a new level needed to flip.
    localparam int c_DEFAULT_DEBOUNCE_CYCLES = 4;

    // Stable level presented while sitting in a given state.
    function automatic logic st_level(input state_t st);
        return st[1];
    endfunction

endpackage : ab_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One conditioning channel: two-flop synchroniser followed by
//                a four-state debounce FSM with a saturating-free run counter.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset
//                raw        - raw asynchronous input
//                level      - debounced stable level (registered)
//                rise       - one-cycle pulse, level 0->1 (registered)
//                fall       - one-cycle pulse, level 1->0 (registered)
//                change_nxt - combinational: a transition completes on the
//                             coming edge (lets the parent register a pair
//                             strobe aligned with rise/fall)
//  Revision    : 1.0  - initial release
// ============================================================================
module debounce_channel
    import ab_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic change_nxt
);

    // Count value on which the last required sample arrives.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    // Synchroniser chain raw -> s1 -> s2; only s2 is used downstream.
    logic r_s1;
    logic r_s2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // ------------------------------------------------------------------------
    // Next-state logic. The counter holds the number of consecutive s2
    // samples seen at the candidate level; the sample that takes it to
    // DEBOUNCE_CYCLES completes the transition instead of incrementing, so
    // the counter never exceeds DEBOUNCE_CYCLES-1.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            ST_LOW: begin
                if (r_s2) begin
                    w_state_nxt = ST_CHK_HIGH;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end

            ST_CHK_HIGH: begin
                if (!r_s2) begin
                    // Bounce: discard the partial run silently.
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end

            ST_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = ST_CHK_LOW;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end

            ST_CHK_LOW: begin
                if (r_s2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter, synchroniser and strobe registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_LOW;
            r_cnt   <= c_CNT_ZERO;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Level is a direct state-register bit, so it cannot glitch.
    assign level      = st_level(r_state);
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign change_nxt = w_rise_nxt | w_fall_nxt;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/ab_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : ab_input_conditioner
//  Description : Conditions the raw a/b push-button inputs for the 2-bit
//                Mealy controller: per-channel synchronise + debounce, plus
//                a pair-change strobe.
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                a_raw     - raw asynchronous input, channel A
//                b_raw     - raw asynchronous input, channel B
//                a, b      - debounced stable levels
//                a_rise    - one-cycle pulse on a 0->1
//                a_fall    - one-cycle pulse on a 1->0
//                b_rise    - one-cycle pulse on b 0->1
//                b_fall    - one-cycle pulse on b 1->0
//                ab_change - one-cycle pulse whenever {a,b} changes
//  Revision    : 1.0  - initial release
// ============================================================================
module ab_input_conditioner
    import ab_cond_pkg::*;
#(
    // Legal range: DEBOUNCE_CYCLES >= 2.
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic ab_change
);

    logic w_a_change_nxt;
    logic w_b_change_nxt;
    logic r_ab_change;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk        (clk),
        .rst        (rst),
        .raw        (a_raw),
        .level      (a),
        .rise       (a_rise),
        .fall       (a_fall),
        .change_nxt (w_a_change_nxt)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk        (clk),
        .rst        (rst),
        .raw        (b_raw),
        .level      (b),
        .rise       (b_rise),
        .fall       (b_fall),
        .change_nxt (w_b_change_nxt)
    );

    // Registered OR of the channel strobes. It is built from the strobes'
    // next values so that it lands on the same edge as rise/fall and the new
    // levels; simultaneous A/B transitions therefore merge into one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ab_change <= 1'b0;
        end else begin
            r_ab_change <= w_a_change_nxt | w_b_change_nxt;
        end
    end

    assign ab_change = r_ab_change;

endmodule : ab_input_conditioner
`default_nettype wire

// File: tb/tb_ab_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ab_input_conditioner
//  Description : Self-checking bench for ab_input_conditioner: vector table,
//                directed corner sequences and a randomized run against a
//                run-length reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ab_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall, ab_change;
    logic [6:0] dut_vec;

    always #5 clk = ~clk;

    ab_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_raw     (a_raw),
        .b_raw     (b_raw),
        .a         (a),
        .b         (b),
        .a_rise    (a_rise),
        .a_fall    (a_fall),
        .b_rise    (b_rise),
        .b_fall    (b_fall),
        .ab_change (ab_change)
    );

    assign dut_vec = {a, b, a_rise, a_fall, b_rise, b_fall, ab_change};

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cycle, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: raw goes through a 2-deep delay line; the stable level
    // flips once D consecutive delayed samples differ from it.
    // ------------------------------------------------------------------------
    bit m_d1[2], m_d2[2], m_lvl[2], m_rise[2], m_fall[2];
    int m_run[2];
    bit m_chg;

    task automatic model_step(input bit r, input bit ra, input bit rb);
        bit raw[2];
        bit samp;
        raw[0] = ra;
        raw[1] = rb;
        m_chg = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (r) begin
                m_d1[ch] = 1'b0; m_d2[ch] = 1'b0; m_lvl[ch] = 1'b0; m_run[ch] = 0;
            end else begin
                samp     = m_d2[ch];
                m_d2[ch] = m_d1[ch];
                m_d1[ch] = raw[ch];
                if (samp != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_lvl[ch]  = samp;
                        m_run[ch]  = 0;
                        m_rise[ch] = samp;
                        m_fall[ch] = !samp;
                        m_chg      = 1'b1;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
    endtask

    function automatic int model_vec();
        return int'({m_lvl[0], m_lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1], m_chg});
    endfunction

    // One clock edge: advance the model with the applied inputs, then compare.
    task automatic tick();
        @(posedge clk);
        model_step(rst, a_raw, b_raw);
        cycle++;
        #1;
        check("model", int'(dut_vec), model_vec());
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        bit         r;
        bit         ra;
        bit         rb;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit ra, input bit rb, input logic [6:0] e);
        vec_t v;
        v.r = r; v.ra = ra; v.rb = rb; v.exp = e;
        tbl.push_back(v);
    endtask

    int found, fb, n_rise, n_fall, n_chg, n_both, n_other;

    initial begin
        // Reset held 3 cycles with both raws high: outputs stay 0.
        for (int i = 0; i < 3; i++) add(1, 1, 1, 7'b0000000);
        // Release: both rise together on the 6th edge, single ab_change.
        for (int i = 0; i < 5; i++) add(0, 1, 1, 7'b0000000);
        add(0, 1, 1, 7'b1110101);
        add(0, 1, 1, 7'b1100000);
        // a_raw released: a falls on the 6th edge.
        for (int i = 0; i < 5; i++) add(0, 0, 1, 7'b1100000);
        add(0, 0, 1, 7'b0101001);
        add(0, 0, 1, 7'b0100000);

        foreach (tbl[i]) begin
            rst = tbl[i].r; a_raw = tbl[i].ra; b_raw = tbl[i].rb;
            tick();
            check($sformatf("table[%0d]", i), int'(dut_vec), int'(tbl[i].exp));
        end

        // Return to an all-zero baseline.
        rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("baseline", int'(dut_vec), 0);

        // Clean press on A.
        a_raw = 1'b1;
        found = 0; n_rise = 0; n_chg = 0; n_other = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a && found == 0) found = i;
            if (a_rise) n_rise++;
            if (ab_change) n_chg++;
            if (b || b_rise || b_fall) n_other++;
        end
        check("press_latency", found, 6);
        check("press_a_rise_cycles", n_rise, 1);
        check("press_ab_change_cycles", n_chg, 1);
        check("press_b_quiet", n_other, 0);

        // Bounce on B: 1x3, 0x1, 1x2, then 0 held.
        n_rise = 0; n_chg = 0; n_other = 0;
        for (int i = 0; i < 16; i++) begin
            b_raw = (i < 3 || i == 4 || i == 5) ? 1'b1 : 1'b0;
            tick();
            if (b) n_other++;
            if (b_rise) n_rise++;
            if (ab_change) n_chg++;
        end
        check("bounce_b_level", n_other, 0);
        check("bounce_b_rise", n_rise, 0);
        check("bounce_ab_change", n_chg, 0);

        // Release A.
        a_raw = 1'b0;
        found = 0; n_fall = 0; n_chg = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (!a && found == 0) found = i;
            if (a_fall) n_fall++;
            if (ab_change) n_chg++;
        end
        check("release_latency", found, 6);
        check("release_a_fall_cycles", n_fall, 1);
        check("release_ab_change_cycles", n_chg, 1);

        // Reset in the middle of a rise check.
        a_raw = 1'b1;
        n_rise = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_rise || a) n_rise++;
        end
        check("midreset_no_early_rise", n_rise, 0);
        rst = 1'b1;
        tick();
        check("midreset_outputs", int'(dut_vec), 0);
        rst = 1'b0;
        found = 0; n_rise = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a && found == 0) found = i;
            if (a_rise) n_rise++;
        end
        check("midreset_latency", found, 6);
        check("midreset_a_rise_cycles", n_rise, 1);

        // Simultaneous rise on both channels.
        a_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("simul_baseline", int'(dut_vec), 0);
        a_raw = 1'b1; b_raw = 1'b1;
        found = 0; fb = 0; n_chg = 0; n_both = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a && found == 0) found = i;
            if (b && fb == 0) fb = i;
            if (ab_change) n_chg++;
            if (a_rise && b_rise) n_both++;
        end
        check("simul_a_latency", found, 6);
        check("simul_b_latency", fb, 6);
        check("simul_ab_change_cycles", n_chg, 1);
        check("simul_joint_rise", n_both, 1);

        // Randomized run: per-channel hold lengths mix bounces with real
        // transitions; occasional single-cycle resets.
        begin
            int hold_a, hold_b;
            hold_a = 0; hold_b = 0;
            for (int i = 0; i < 4000; i++) begin
                if (hold_a == 0) begin
                    a_raw  = ~a_raw;
                    hold_a = int'($urandom_range(1, 10));
                end
                if (hold_b == 0) begin
                    b_raw  = ~b_raw;
                    hold_b = int'($urandom_range(1, 10));
                end
                hold_a--; hold_b--;
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ab_input_conditioner
`default_nettype wire
